// File: rtl/router_in_arb.sv
// Packet-granular round-robin arbiter sharing the router input port among NSRC sources.
// Holds a grant from header through parity, drains, and flags header-length mismatches.
module router_in_arb #(
  parameter int unsigned NSRC = 4,
  parameter int unsigned DW   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NSRC-1:0]    src_pkt_valid,
  input  logic [NSRC*DW-1:0] src_data,
  output logic [NSRC-1:0]    src_busy,
  input  logic               router_busy,
  output logic               pkt_valid,
  output logic [DW-1:0]      data_in,
  output logic [NSRC-1:0]    gnt,
  output logic               len_err
);
  localparam int unsigned PW = $clog2(NSRC);
  localparam int unsigned LW = DW - 2;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, FWD, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [NSRC-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LW-1:0]   len_q, len_d;
  logic [CW-1:0]   pay_cnt_q, pay_cnt_d;
  logic            hdr_seen_q, hdr_seen_d;
  logic            drain_cnt_q, drain_cnt_d;
  logic            len_err_q, len_err_d;

  logic [PW-1:0]   gidx;
  logic            sel_pv;
  logic [DW-1:0]   sel_data;
  logic [PW-1:0]   win;
  logic [PW-1:0]   cand;
  logic            found;

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (gnt_q[i]) gidx = PW'(i);
    end
  end

  assign sel_pv   = src_pkt_valid[gidx];
  assign sel_data = src_data[gidx*DW +: DW];

  // Round-robin search starts just after the last winner
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NSRC; k++) begin
      cand = PW'((32'(rr_ptr_q) + k) % NSRC);
      if (!found && src_pkt_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    src_busy  = '1;
    pkt_valid = 1'b0;
    data_in   = '0;
    if (gnt_q != '0) begin
      data_in = sel_data;
      if (state_q == FWD) begin
        pkt_valid      = sel_pv;
        src_busy[gidx] = router_busy;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    len_d       = len_q;
    pay_cnt_d   = pay_cnt_q;
    hdr_seen_d  = hdr_seen_q;
    drain_cnt_d = drain_cnt_q;
    len_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!router_busy && found) begin
          gnt_d       = '0;
          gnt_d[win]  = 1'b1;
          rr_ptr_d    = win;
          hdr_seen_d  = 1'b0;
          pay_cnt_d   = '0;
          state_d     = FWD;
        end
      end
      FWD: begin
        if (!router_busy) begin
          if (sel_pv) begin
            if (!hdr_seen_q) begin
              len_d      = sel_data[DW-1:2];
              pay_cnt_d  = '0;
              hdr_seen_d = 1'b1;
            end else if (pay_cnt_q != '1) begin
              pay_cnt_d = pay_cnt_q + 1'b1;
            end
          end else begin
            // Byte presented with pkt_valid low is the parity byte
            len_err_d   = (32'(pay_cnt_q) != 32'(len_q));
            drain_cnt_d = 1'b0;
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!drain_cnt_q) begin
          drain_cnt_d = 1'b1;
        end else if (!router_busy) begin
          gnt_d       = '0;
          hdr_seen_d  = 1'b0;
          pay_cnt_d   = '0;
          drain_cnt_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= PW'(NSRC - 1);
      len_q       <= '0;
      pay_cnt_q   <= '0;
      hdr_seen_q  <= 1'b0;
      drain_cnt_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      len_q       <= len_d;
      pay_cnt_q   <= pay_cnt_d;
      hdr_seen_q  <= hdr_seen_d;
      drain_cnt_q <= drain_cnt_d;
      len_err_q   <= len_err_d;
    end
  end

  assign gnt     = gnt_q;
  assign len_err = len_err_q;

endmodule

// File: tb/tb_router_in_arb.sv
// Randomized bench for router_in_arb: packet-level sources and a behavioural
// arbiter model compared every cycle, plus a directed opening with literal checks.
module tb_router_in_arb;
  localparam int NS  = 4;
  localparam int RND = 20;
  localparam int NCYC = 4000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          router_busy = 1'b0;
  logic [NS-1:0] src_pkt_valid;
  logic [NS*8-1:0] src_data;
  logic [NS-1:0] src_busy;
  logic          pkt_valid;
  logic [7:0]    data_in;
  logic [NS-1:0] gnt;
  logic          len_err;

  router_in_arb #(.NSRC(NS), .DW(8)) dut (
    .clock(clock), .reset(reset), .src_pkt_valid(src_pkt_valid), .src_data(src_data),
    .src_busy(src_busy), .router_busy(router_busy), .pkt_valid(pkt_valid),
    .data_in(data_in), .gnt(gnt), .len_err(len_err)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  // Sources: byte 0 header, 1..npay payload, npay+1 parity
  bit         s_act [NS];
  int         s_pos [NS];
  int         s_npay[NS];
  int         s_gap [NS];
  logic [7:0] s_byte[NS][16];

  // Model: owner (-1 none), phase 0 idle / 1 forwarding / 2 draining
  int m_owner, m_phase, m_dcyc, m_last, m_len, m_cnt;
  bit m_hdr, m_err;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic load_pkt(input int s, input logic [7:0] hdr, input int npay);
    logic [7:0] par;
    s_act[s] = 1'b1;
    s_pos[s] = 0;
    s_npay[s] = npay;
    s_byte[s][0] = hdr;
    par = hdr;
    for (int i = 1; i <= npay; i++) begin
      s_byte[s][i] = 8'($urandom);
      par = par ^ s_byte[s][i];
    end
    s_byte[s][npay+1] = par;
  endtask

  initial begin
    logic [NS-1:0] exp_gnt, exp_busy;
    logic          exp_pv;
    logic [7:0]    exp_data;
    logic [5:0]    rl;
    bit            prev_rst;
    bit            picked;
    int            o, c, npay;
    prev_rst = 1'b0;
    m_owner = -1; m_phase = 0; m_last = NS-1; m_err = 0; m_hdr = 0; m_cnt = 0; m_len = 0; m_dcyc = 0;
    for (int s = 0; s < NS; s++) begin
      s_act[s] = 0; s_pos[s] = 0; s_npay[s] = 0; s_gap[s] = 0;
    end
    for (int n = 0; n < NCYC; n++) begin
      @(negedge clock);
      if (n < 2) reset = 1'b1;
      else if (n >= RND && $urandom_range(0, 349) == 0) reset = 1'b1;
      else reset = 1'b0;
      if (n == 2)  load_pkt(0, 8'h0D, 3);
      if (n == 10) load_pkt(1, 8'h15, 3);
      if (n >= RND) begin
        for (int s = 0; s < NS; s++) begin
          if (!s_act[s]) begin
            if (s_gap[s] == 0) begin
              rl = 6'($urandom_range(0, 6));
              npay = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'(rl);
              load_pkt(s, {rl, 2'($urandom_range(0, 3))}, npay);
            end else s_gap[s]--;
          end
        end
        router_busy = (n % 500 < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      end else router_busy = 1'b0;
      for (int s = 0; s < NS; s++) begin
        if (s_act[s]) begin
          src_pkt_valid[s] = (s_pos[s] <= s_npay[s]);
          src_data[s*8 +: 8] = s_byte[s][s_pos[s]];
        end else begin
          src_pkt_valid[s] = 1'b0;
          src_data[s*8 +: 8] = 8'($urandom);
        end
      end
      #1;
      if (n > 0) begin
        exp_gnt = (m_owner >= 0) ? NS'(1 << m_owner) : '0;
        exp_busy = '1; exp_pv = 1'b0; exp_data = '0;
        if (m_phase == 1) begin
          exp_pv = src_pkt_valid[m_owner];
          exp_data = src_data[m_owner*8 +: 8];
          exp_busy[m_owner] = router_busy;
        end
        chk("gnt", n, 32'(gnt), 32'(exp_gnt));
        chk("src_busy", n, 32'(src_busy), 32'(exp_busy));
        chk("pkt_valid", n, 32'(pkt_valid), 32'(exp_pv));
        chk("len_err", n, 32'(len_err), 32'(m_err));
        if (m_phase != 2) chk("data_in", n, 32'(data_in), 32'(exp_data));
        case (n)
          1:  begin chk("lit_rst_gnt", n, 32'(gnt), 32'h0); chk("lit_rst_busy", n, 32'(src_busy), 32'hF); end
          3:  begin chk("lit_gnt0", n, 32'(gnt), 32'h1); chk("lit_hdr", n, 32'(data_in), 32'h0D); end
          8:  begin chk("lit_ok_len", n, 32'(len_err), 32'h0); chk("lit_drain_pv", n, 32'(pkt_valid), 32'h0); end
          9:  chk("lit_drain_gnt", n, 32'(gnt), 32'h1);
          10: chk("lit_release", n, 32'(gnt), 32'h0);
          11: chk("lit_gnt1", n, 32'(gnt), 32'h2);
          16: chk("lit_len_err", n, 32'(len_err), 32'h1);
          17: chk("lit_len_pulse", n, 32'(len_err), 32'h0);
          18: chk("lit_release2", n, 32'(gnt), 32'h0);
          default: ;
        endcase
        if (prev_rst && n > RND) begin
          chk("lit_post_rst_gnt", n, 32'(gnt), 32'h0);
          chk("lit_post_rst_busy", n, 32'(src_busy), 32'hF);
        end
      end
      prev_rst = reset;
      // Advance model and sources to what the coming rising edge must produce
      if (reset) begin
        m_owner = -1; m_phase = 0; m_last = NS-1; m_err = 0; m_hdr = 0; m_cnt = 0;
        for (int s = 0; s < NS; s++) begin
          s_act[s] = 0; s_gap[s] = $urandom_range(0, 5);
        end
      end else begin
        m_err = 0;
        case (m_phase)
          0: if (!router_busy && src_pkt_valid != '0) begin
               picked = 0;
               for (int k = 1; k <= NS; k++) begin
                 c = (m_last + k) % NS;
                 if (!picked && src_pkt_valid[c]) begin
                   picked = 1; m_owner = c; m_last = c;
                 end
               end
               m_phase = 1; m_hdr = 0; m_cnt = 0;
             end
          1: if (!router_busy) begin
               o = m_owner;
               if (src_pkt_valid[o]) begin
                 if (!m_hdr) begin
                   m_len = int'(src_data[o*8 +: 8]) / 4; m_hdr = 1; m_cnt = 0;
                 end else if (m_cnt < 63) m_cnt++;
                 s_pos[o]++;
               end else begin
                 m_err = (m_cnt != m_len);
                 m_phase = 2; m_dcyc = 0;
                 s_act[o] = 0; s_gap[o] = $urandom_range(0, 4);
               end
             end
          default: begin
               m_dcyc++;
               if (m_dcyc >= 2 && !router_busy) begin
                 m_owner = -1; m_phase = 0;
               end
             end
        endcase
      end
      @(posedge clock);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
